inst_encoder: RTL
=================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter INST_BITS, default 32, instruction word width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_valid, input, 1, field set on the i_ inputs is valid.
REQ-005 SHALL have port o_ready, output, 1, encoder can accept a field set this cycle.
REQ-006 SHALL have port i_opcode, input, 6, opcode (becomes inst[31:26]).
REQ-007 SHALL have port i_dst, input, 5, destination register field.
REQ-008 SHALL have port i_src0, input, 5, source 0 register field.
REQ-009 SHALL have port i_src1, input, 5, source 1 register field.
REQ-010 SHALL have port i_imm, input, 16, minor immediate.
REQ-011 SHALL have port i_addr, input, 26, jump address.
REQ-012 SHALL have port o_inst, output, INST_BITS, encoded instruction word.
REQ-013 SHALL have port o_inst_valid, output, 1, o_inst holds a valid word.
REQ-014 SHALL have port i_inst_ready, input, 1, downstream accepts o_inst this cycle.
REQ-015 SHALL have port o_illegal, output, 1, one-cycle pulse when an illegal opcode is accepted.
REQ-016 SHALL have port o_illegal_cnt, output, 8, saturating count of illegal opcodes accepted.

Function
REQ-017 SHALL define input accept as i_valid && o_ready and output transfer as o_inst_valid && i_inst_ready.
REQ-018 SHALL treat these opcodes as legal: 0,2,4,6,8,10,12,14 (iAdd..fDev); 16-23 (and, or, xor, ucmp, Lsft, Rsft, cmp, jr); 32,34,36,38 (iAddi..iDevi); 40-47 (lw, sw, Lsfti, Rsfti, be, bne, cmpi, ucmpi); 48,49 (j, jal). All other opcodes SHALL be illegal.
REQ-019 SHALL use R format when opcode[5]=0: {opcode, dst[25:21], src0[20:16], src1[15:11], 11'b0}.
REQ-020 SHALL use I format when opcode[5:4]=2'b10: {opcode, dst[25:21], src0[20:16], imm[15:0]}.
REQ-021 SHALL use J format when opcode[5:4]=2'b11: {opcode, addr[25:0]}.
REQ-022 SHALL ignore input fields unused by the selected format; reserved bits SHALL be 0.
REQ-023 SHALL register the encoded word, so a legal accept into an empty block gives o_inst_valid=1 on the next cycle (latency 1).
REQ-024 SHALL buffer outputs in a 2-entry skid buffer (output register plus skid register), with o_ready = !skid_valid, a registered signal with no combinational path from i_inst_ready.
REQ-025 On accept: if the output register is empty or transferring this cycle and the skid is empty, the word SHALL load the output register; otherwise it SHALL load the skid register.
REQ-026 On transfer with the skid full, the skid word SHALL move to the output register in the same cycle.
REQ-027 SHALL sustain one word per cycle when i_inst_ready=1, with no bubbles on simultaneous accept and transfer.
REQ-028 SHALL emit words strictly in accept order; no word dropped or duplicated.
REQ-029 SHALL hold o_inst stable while o_inst_valid=1 and i_inst_ready=0.
REQ-030 An accepted illegal opcode SHALL consume the handshake, produce no output word, pulse o_illegal the next cycle, and increment o_illegal_cnt, which SHALL saturate at 255.
REQ-031 SHALL ignore i_opcode and the field inputs when i_valid=0.

Reset
REQ-032 While rst=1: o_inst_valid=0, skid empty, o_ready=0, o_inst=0, o_illegal=0, o_illegal_cnt=0.
REQ-033 o_ready SHALL be 1 the first cycle after rst deasserts.
REQ-034 Reset asserted mid-operation SHALL discard all buffered words with no partial output.

Verification
REQ-035 opcode=0, dst=1, src0=2, src1=3, i_inst_ready=1 -> next cycle o_inst=0x00221800, o_inst_valid=1.
REQ-036 opcode=32, dst=1, src0=2, imm=3 -> 0x80220003; opcode=48, addr=4 -> 0xC0000004; opcode=23, src0=1, others 0 -> 0x5C010000.
REQ-037 i_inst_ready=0, push iSub, iMul, iDev (0x08221800, 0x10221800, 0x18221800) -> o_ready=0 after two accepts, third held; raise i_inst_ready -> all three emitted in order, then o_ready=1.
REQ-038 Push opcode 1 then 0x00221800 -> o_illegal pulses once, o_illegal_cnt=1, only 0x00221800 emitted; 300 illegal pushes -> count stays 255.
REQ-039 Fill both entries, assert rst one cycle -> o_inst_valid=0 and o_illegal_cnt=0 next cycle, no stale word emitted after release.
REQ-040 Random valid/ready throttling over all 30 legal opcodes -> output sequence matches a reference model exactly.

Source files
------------

// File: rtl/inst_encoder.sv
// Instruction word encoder: packs R/I/J field sets into 32-bit words, flags illegal
// opcodes and buffers output words in a two-entry skid buffer.
module inst_encoder #(
    parameter int unsigned INST_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [5:0]           i_opcode,
    input  logic [4:0]           i_dst,
    input  logic [4:0]           i_src0,
    input  logic [4:0]           i_src1,
    input  logic [15:0]          i_imm,
    input  logic [25:0]          i_addr,
    output logic [INST_BITS-1:0] o_inst,
    output logic                 o_inst_valid,
    input  logic                 i_inst_ready,
    output logic                 o_illegal,
    output logic [7:0]           o_illegal_cnt
);

    logic [INST_BITS-1:0] r_out;
    logic                 r_out_valid;
    logic [INST_BITS-1:0] r_skid;
    logic                 r_skid_valid;
    logic                 r_illegal;
    logic [7:0]           r_illegal_cnt;

    logic                 w_legal;
    logic [INST_BITS-1:0] w_word;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_xfer;

    // Opcode map is sparse; each quadrant (opcode[5:4]) has its own legality rule.
    always_comb begin
        w_legal = 1'b0;
        case (i_opcode[5:4])
            2'b00:   w_legal = ~i_opcode[0];
            2'b01:   w_legal = ~i_opcode[3];
            2'b10:   w_legal = i_opcode[3] | ~i_opcode[0];
            2'b11:   w_legal = (i_opcode[3:1] == 3'b000);
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_word = '0;
        if (!i_opcode[5]) begin
            w_word = {i_opcode, i_dst, i_src0, i_src1, 11'b0};
        end else if (!i_opcode[4]) begin
            w_word = {i_opcode, i_dst, i_src0, i_imm};
        end else begin
            w_word = {i_opcode, i_addr};
        end
    end

    // Ready depends only on registered skid state, gated low while reset is held.
    assign o_ready  = !r_skid_valid && !rst;
    assign w_accept = i_valid && o_ready;
    assign w_push   = w_accept && w_legal;
    assign w_xfer   = r_out_valid && i_inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out         <= '0;
            r_out_valid   <= 1'b0;
            r_skid        <= '0;
            r_skid_valid  <= 1'b0;
            r_illegal     <= 1'b0;
            r_illegal_cnt <= 8'd0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_illegal_cnt != 8'hFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end

            if (w_xfer) begin
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end

            // A push can only happen with the skid empty, so it never collides with
            // the skid-to-output move above.
            if (w_push) begin
                if ((!r_out_valid || w_xfer) && !r_skid_valid) begin
                    r_out       <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_skid       <= w_word;
                    r_skid_valid <= 1'b1;
                end
            end
        end
    end

    assign o_inst        = r_out;
    assign o_inst_valid  = r_out_valid;
    assign o_illegal     = r_illegal;
    assign o_illegal_cnt = r_illegal_cnt;

endmodule
